// File: rtl/game_start_ctrl.sv
// Two-player start controller: synchronizes and debounces both push-buttons,
// then requires both keys to be held for HOLD_CYCLES before emitting a single
// start pulse. The FSM waits for both keys to be let go before it can re-arm.
module game_start_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_a_n,
    input  logic       key_b_n,
    output logic       start,
    output logic       armed,
    output logic [1:0] state
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        ARMING       = 2'b01,
        FIRE         = 2'b10,
        WAIT_RELEASE = 2'b11
    } state_t;

    state_t cur_state;

    logic sync_a_p0, sync_a_p1;
    logic sync_b_p0, sync_b_p1;
    logic pressed_a, pressed_b;

    logic             deb_a, deb_b;
    logic [DEB_W-1:0] deb_cnt_a, deb_cnt_b;

    logic [HOLD_W-1:0] hold_cnt;

    logic both_pressed;
    logic both_released;

    // Two-flop synchronizers; the released (high) level is the safe reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a_p0 <= 1'b1;
            sync_a_p1 <= 1'b1;
            sync_b_p0 <= 1'b1;
            sync_b_p1 <= 1'b1;
        end else begin
            sync_a_p0 <= key_a_n;
            sync_a_p1 <= sync_a_p0;
            sync_b_p0 <= key_b_n;
            sync_b_p1 <= sync_b_p0;
        end
    end

    // Buttons are active-low on the pins; everything downstream is active-high.
    assign pressed_a = ~sync_a_p1;
    assign pressed_b = ~sync_b_p1;

    // Debouncer A: flip the level only after DEBOUNCE_CYCLES straight mismatches.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_a     <= 1'b0;
            deb_cnt_a <= '0;
        end else if (pressed_a == deb_a) begin
            deb_cnt_a <= '0;
        end else if (deb_cnt_a == DEB_LAST) begin
            deb_a     <= ~deb_a;
            deb_cnt_a <= '0;
        end else begin
            deb_cnt_a <= deb_cnt_a + DEB_W'(1);
        end
    end

    // Debouncer B: identical behaviour, independent counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_b     <= 1'b0;
            deb_cnt_b <= '0;
        end else if (pressed_b == deb_b) begin
            deb_cnt_b <= '0;
        end else if (deb_cnt_b == DEB_LAST) begin
            deb_b     <= ~deb_b;
            deb_cnt_b <= '0;
        end else begin
            deb_cnt_b <= deb_cnt_b + DEB_W'(1);
        end
    end

    assign both_pressed  = deb_a & deb_b;
    assign both_released = ~deb_a & ~deb_b;

    // Start FSM; start and armed are registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            hold_cnt  <= '0;
            start     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            start <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (both_pressed) begin
                        cur_state <= ARMING;
                        hold_cnt  <= '0;
                        armed     <= 1'b1;
                    end
                end
                ARMING: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    // A release wins over a fire landing on the same edge.
                    if (!both_pressed) begin
                        cur_state <= IDLE;
                        armed     <= 1'b0;
                    end else if (hold_cnt >= HOLD_LAST) begin
                        cur_state <= FIRE;
                        armed     <= 1'b0;
                        start     <= 1'b1;
                    end
                end
                FIRE: begin
                    cur_state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (both_released) begin
                        cur_state <= IDLE;
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    armed     <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_game_start_ctrl.sv
// Bench for game_start_ctrl: a cycle-level reference model predicts the
// outputs after each edge into a scoreboard queue, a monitor compares them,
// and directed scenarios check the headline latencies as absolute edge counts.
module tb_game_start_ctrl;

    localparam int D  = 4;
    localparam int H  = 3;
    localparam int HL = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_a_n;
    logic       key_b_n;
    logic       start, armed;
    logic [1:0] state;
    logic       long_start, long_armed;
    logic [1:0] long_state;

    always #5 clk = ~clk;

    game_start_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .key_a_n(key_a_n), .key_b_n(key_b_n),
        .start(start), .armed(armed), .state(state)
    );

    // Same inputs, longer hold, so a release can beat the fire.
    game_start_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HL)) dut_long (
        .clk(clk), .reset(reset), .key_a_n(key_a_n), .key_b_n(key_b_n),
        .start(long_start), .armed(long_armed), .state(long_state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       ar;
        logic       sp;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference model: key pipelines, mismatch run lengths, phase and time held.
    bit m_s1[2], m_s2[2], m_deb[2];
    int m_run[2];
    int m_phase;
    int m_held;

    function automatic exp_t model_step(input bit r, input bit an, input bit bn);
        exp_t o;
        bit   keys[2];
        bit   da, db;
        keys[0] = an;
        keys[1] = bn;
        da = m_deb[0];
        db = m_deb[1];
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_deb[k] = 1'b0; m_run[k] = 0;
            end
            m_phase = 0;
            m_held  = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_s2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_deb[k] = !m_deb[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = keys[k];
            end
            case (m_phase)
                0: if (da && db) begin m_phase = 1; m_held = 0; end
                1: begin
                    if (m_held < H) m_held++;
                    if (!(da && db)) m_phase = 0;
                    else if (m_held >= H) m_phase = 2;
                end
                2: m_phase = 3;
                default: if (!da && !db) m_phase = 0;
            endcase
        end
        o.st = 2'(m_phase);
        o.ar = (m_phase == 1);
        o.sp = (m_phase == 2);
        return o;
    endfunction

    task automatic step(input bit r, input bit an, input bit bn);
        exp_t e;
        reset   = r;
        key_a_n = an;
        key_b_n = bn;
        e = model_step(r, an, bn);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compare each presented output set against the predicted one.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_state", 32'(state), 32'(e.st));
            check("sb_armed", 32'(armed), 32'(e.ar));
            check("sb_start", 32'(start), 32'(e.sp));
        end
    end

    initial begin
        int first_armed, start_edge, starts, bad, long_starts, dur, sel;
        bit an, bn;
        reset = 1'b1; key_a_n = 1'b1; key_b_n = 1'b1;

        // Reset state
        step(1, 1, 1);
        step(1, 1, 1);
        check("reset_state", 32'(state), 0);
        check("reset_armed", 32'(armed), 0);
        check("reset_start", 32'(start), 0);
        check("reset_long_state", 32'(long_state), 0);

        // Both keys held from edge 1
        first_armed = 0; start_edge = 0; starts = 0;
        for (int e = 1; e <= 19; e++) begin
            step(0, 0, 0);
            if (armed && first_armed == 0) first_armed = e;
            if (start) begin starts++; start_edge = e; end
        end
        check("armed_edge", first_armed, 7);
        check("start_edge", start_edge, 10);
        check("start_count", starts, 1);
        check("wait_release_state", 32'(state), 3);
        for (int e = 20; e <= 32; e++) begin
            step(0, 1, 1);
            if (start) starts++;
        end
        check("no_refire", starts, 1);
        check("release_idle", 32'(state), 0);

        // Single key held alone
        starts = 0; bad = 0;
        for (int e = 0; e < 50; e++) begin
            step(0, 0, 1);
            if (start) starts++;
            if (state != 2'b00) bad++;
        end
        check("single_key_state", bad, 0);
        check("single_key_start", starts, 0);
        for (int e = 0; e < 10; e++) step(0, 1, 1);

        // Short key_b glitch during ARMING
        step(1, 1, 1);
        start_edge = 0; starts = 0;
        for (int e = 1; e <= 19; e++) begin
            step(0, 0, (e == 8 || e == 9));
            if (start) begin starts++; start_edge = e; end
        end
        check("glitch_start_edge", start_edge, 10);
        check("glitch_start_count", starts, 1);
        for (int e = 0; e < 15; e++) step(0, 1, 1);

        // key_b released 6 cycles during ARMING (long-hold instance aborts)
        step(1, 1, 1);
        long_starts = 0;
        for (int e = 1; e <= 24; e++) begin
            step(0, 0, (e >= 8 && e <= 13));
            if (e <= 22 && long_start) long_starts++;
            if (e == 13) check("long_armed_before_release", 32'(long_armed), 1);
            if (e == 14) begin
                check("long_abort_state", 32'(long_state), 0);
                check("long_abort_armed", 32'(long_armed), 0);
            end
        end
        check("long_abort_no_start", long_starts, 0);
        for (int e = 0; e < 20; e++) step(0, 1, 1);

        // Reset mid-ARMING with keys held
        step(1, 1, 1);
        for (int e = 1; e <= 8; e++) begin
            step(0, 0, 0);
            if (e == 7) check("pre_reset_armed", 32'(armed), 1);
        end
        step(1, 0, 0);
        check("midarm_reset_state", 32'(state), 0);
        check("midarm_reset_armed", 32'(armed), 0);
        check("midarm_reset_start", 32'(start), 0);
        start_edge = 0; starts = 0;
        for (int e = 1; e <= 12; e++) begin
            step(0, 0, 0);
            if (start) begin starts++; start_edge = e; end
        end
        check("post_reset_start_edge", start_edge, 10);
        check("post_reset_start_count", starts, 1);
        for (int e = 0; e < 15; e++) step(0, 1, 1);

        // Randomized traffic
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                step(1, $urandom_range(0, 1), $urandom_range(0, 1));
            end else begin
                sel = $urandom_range(0, 3);
                dur = (sel == 0) ? $urandom_range(5, 25) : $urandom_range(1, 10);
                for (int c = 0; c < dur; c++) begin
                    case (sel)
                        0:       begin an = 0; bn = (c == 9) ? bit'($urandom_range(0, 1)) : 1'b0; end
                        1:       begin an = bit'($urandom_range(0, 1)); bn = 1; end
                        2:       begin an = 1; bn = 1; end
                        default: begin an = bit'($urandom_range(0, 1)); bn = bit'($urandom_range(0, 1)); end
                    endcase
                    step(0, an, bn);
                end
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_start_ctrl.md
GAME_START_CTRL -- requirements
Module: game_start_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, giving the consecutive stable cycles required before a debounced key changes state (legal range 1 to 2^20-1).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 25000000, giving the cycles both keys must stay held in ARMING before start fires (legal range 1 to 2^26-1).
REQ-003 Port clk SHALL be an input, 1 bit wide: the system clock, with all state updating on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: reset, synchronous, active-high.
REQ-005 Port key_a_n SHALL be an input, 1 bit wide: player A raw push-button, asynchronous, active-low.
REQ-006 Port key_b_n SHALL be an input, 1 bit wide: player B raw push-button, asynchronous, active-low.
REQ-007 Port start SHALL be an output, 1 bit wide: a one-cycle pulse that drives the ctrl input of the downstream game-active latch.
REQ-008 Port armed SHALL be an output, 1 bit wide: high while the FSM is in ARMING.
REQ-009 Port state SHALL be an output, 2 bits wide: the FSM encoding, exposed for debug.

Function
REQ-010 Each raw key SHALL pass through its own 2-flop synchronizer, then be inverted to form an active-high pressed level.
REQ-011 Each key SHALL have an independent debouncer: a counter clears whenever the synchronized level equals the debounced level, and increments each cycle the two differ.
REQ-012 A debounced level SHALL toggle on the edge that completes DEBOUNCE_CYCLES consecutive mismatch cycles, and its counter SHALL clear on that same edge.
REQ-013 A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced level.
REQ-014 The FSM SHALL have states IDLE=2'b00, ARMING=2'b01, FIRE=2'b10 and WAIT_RELEASE=2'b11.
REQ-015 In IDLE, the FSM SHALL move to ARMING and clear the hold counter when both debounced keys are pressed; otherwise it SHALL remain in IDLE.
REQ-016 In ARMING, the hold counter SHALL increment each cycle.
REQ-017 In ARMING, the FSM SHALL return to IDLE if either debounced key is released, with release taking priority over fire on the same cycle.
REQ-018 In ARMING, the FSM SHALL move to FIRE on the edge that completes HOLD_CYCLES cycles in ARMING with both keys held.
REQ-019 In FIRE, start SHALL be 1 for exactly one cycle, and the FSM SHALL unconditionally move to WAIT_RELEASE.
REQ-020 In WAIT_RELEASE, the FSM SHALL remain until both debounced keys are released, then move to IDLE; start SHALL NOT re-fire while the keys are still held.
REQ-021 start and armed SHALL be registered state decodes with no combinational path from any key input.
REQ-022 Latency: with both keys pressed from before edge 1 and stable, debounced levels SHALL assert after edge 2+DEBOUNCE_CYCLES, ARMING SHALL be entered at edge 3+DEBOUNCE_CYCLES, and start SHALL be high for the cycle following edge 3+DEBOUNCE_CYCLES+HOLD_CYCLES.
REQ-023 Counter widths SHALL be sized from the parameters using $clog2 and SHALL never wrap; the hold counter SHALL saturate at HOLD_CYCLES.
REQ-024 A key pressed alone SHALL never leave IDLE, regardless of how long it is held.

Reset
REQ-025 While reset=1 at a rising edge: synchronizer flops SHALL load 1 (released), debounced levels SHALL load 0, all counters SHALL load 0, and state SHALL load IDLE.
REQ-026 While reset=1, outputs SHALL read start=0, armed=0 and state=2'b00.
REQ-027 Reset asserted mid-ARMING or mid-WAIT_RELEASE SHALL abort on that edge with no start pulse.
REQ-028 After release from reset, keys already held SHALL be debounced afresh as a new press, giving the full REQ-022 latency.
REQ-029 Reset SHALL override every other condition on the same edge.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=3)
REQ-030 Drive both keys low before edge 1 and hold -> armed=1 from edge 7, start=1 only between edges 10 and 11, then state=2'b11 while held.
REQ-031 Continue holding both keys, then release both at edge 20 -> state returns to 2'b00 after debounce and start stays 0 throughout.
REQ-032 Drive key_a_n low alone for 50 cycles -> state stays 2'b00 and start never asserts.
REQ-033 Press both keys, then pulse key_b_n high for 2 cycles during ARMING -> debounced level is unaffected and start fires on schedule.
REQ-034 Press both keys, then release key_b_n for 6 cycles during ARMING -> FSM returns to IDLE and start is not asserted.
REQ-035 Assert reset for 1 cycle in ARMING while keys are held -> state=2'b00 with no start, then start fires 3+DEBOUNCE_CYCLES+HOLD_CYCLES edges after reset deasserts.
